pll_capbank_cal_tmr: RTL and testbench



---
 rtl/pll_cal_pkg.sv | 30 +++
 rtl/pll_capbank_cal_tmr_if.sv | 25 ++
 rtl/pll_cal_sar_next.sv | 87 ++++++++
 rtl/pll_capbank_cal_tmr.sv | 100 ++++++++++
 tb/tb_pll_capbank_cal_tmr.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pll_cal_pkg.sv
// Shared types and helpers for the triplicated PLL cap-bank calibration engine.
// Holds the state encoding, the mid-scale start code and the 2-of-3 voters.
package pll_cal_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SETTLE   = 2'd1,
      WAIT_CMP = 2'd2,
      DONE     = 2'd3
   } cal_state_e;

   localparam logic [5:0] CAL_MID_CODE = 6'b100000;
   localparam logic [2:0] CAL_TOP_BIT  = 3'd5;

   function automatic logic [1:0] maj3_w2(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [2:0] maj3_w3(input logic [2:0] a, input logic [2:0] b,
                                          input logic [2:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic [5:0] maj3_w6(input logic [5:0] a, input logic [5:0] b,
                                          input logic [5:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/pll_capbank_cal_tmr_if.sv
// Control, comparator and replicated-code signals of the cap-bank calibration engine.
// The engine takes the slave side; whoever drives start/comparator takes the master side.
interface pll_capbank_cal_tmr_if;
   logic       cal_en;
   logic       start;
   logic [5:0] manual_code;
   logic       cmp_valid;
   logic       vco_fast;
   logic [5:0] codeA;
   logic [5:0] codeB;
   logic [5:0] codeC;
   logic       busy;
   logic       done;
   logic       timeout_err;

   modport master (
      output cal_en, start, manual_code, cmp_valid, vco_fast,
      input  codeA, codeB, codeC, busy, done, timeout_err
   );

   modport slave (
      input  cal_en, start, manual_code, cmp_valid, vco_fast,
      output codeA, codeB, codeC, busy, done, timeout_err
   );
endinterface

// File: rtl/pll_cal_sar_next.sv
// Combinational next-state logic of the SAR search, evaluated once on the voted
// state/bit/code; its results are fanned out to every replica register.
module pll_cal_sar_next
   import pll_cal_pkg::*;
#(
   parameter int unsigned SETTLE_CYC  = 64,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned CNT_W       = 13
) (
   input  cal_state_e       state,
   input  logic [2:0]       bit_idx,
   input  logic [5:0]       code,
   input  logic [CNT_W-1:0] cnt,
   input  logic             cal_en,
   input  logic             start,
   input  logic [5:0]       manual_code,
   input  logic             cmp_valid,
   input  logic             vco_fast,
   output cal_state_e       state_d,
   output logic [2:0]       bit_d,
   output logic [5:0]       code_d,
   output logic [CNT_W-1:0] cnt_d,
   output logic             run_start,
   output logic             run_ok,
   output logic             run_tmo
);

   always_comb begin
      state_d   = state;
      bit_d     = bit_idx;
      code_d    = code;
      cnt_d     = cnt;
      run_start = 1'b0;
      run_ok    = 1'b0;
      run_tmo   = 1'b0;
      if (!cal_en) begin
         state_d = IDLE;
         bit_d   = CAL_TOP_BIT;
         code_d  = manual_code;
         cnt_d   = '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state_d   = SETTLE;
                  bit_d     = CAL_TOP_BIT;
                  code_d    = CAL_MID_CODE;
                  cnt_d     = '0;
                  run_start = 1'b1;
               end
            end
            SETTLE: begin
               if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
                  cnt_d   = '0;
                  state_d = WAIT_CMP;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            WAIT_CMP: begin
               // A verdict on the final timeout cycle still wins over the abort.
               if (cmp_valid) begin
                  cnt_d = '0;
                  if (!vco_fast) code_d[bit_idx] = 1'b0;
                  if (bit_idx != 3'd0) begin
                     code_d[bit_idx - 3'd1] = 1'b1;
                     bit_d                  = bit_idx - 3'd1;
                     state_d                = SETTLE;
                  end else begin
                     state_d = DONE;
                     run_ok  = 1'b1;
                  end
               end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                  cnt_d   = '0;
                  code_d  = CAL_MID_CODE;
                  state_d = DONE;
                  run_tmo = 1'b1;
               end else begin
                  cnt_d = cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pll_capbank_cal_tmr.sv
// PLL VCO cap-bank SAR calibration with triplicated state/bit/code registers.
// Each replica reloads from the 2-of-3 vote, so a single upset clears on the next clock.
module pll_capbank_cal_tmr
   import pll_cal_pkg::*;
#(
   parameter int unsigned SETTLE_CYC  = 64,
   parameter int unsigned TIMEOUT_CYC = 4096,
   parameter int unsigned CNT_W       = 13
) (
   input logic                  clk,
   input logic                  rstn,
   pll_capbank_cal_tmr_if.slave cal
);

   cal_state_e       state_q_a, state_q_b, state_q_c;
   logic [2:0]       bit_q_a, bit_q_b, bit_q_c;
   logic [5:0]       code_q_a, code_q_b, code_q_c;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q, done_q, tmo_q;

   cal_state_e       state_v, state_d;
   logic [2:0]       bit_v, bit_d;
   logic [5:0]       code_v, code_d;
   logic [CNT_W-1:0] cnt_d;
   logic             run_start, run_ok, run_tmo;

   assign state_v = cal_state_e'(maj3_w2(state_q_a, state_q_b, state_q_c));
   assign bit_v   = maj3_w3(bit_q_a, bit_q_b, bit_q_c);
   assign code_v  = maj3_w6(code_q_a, code_q_b, code_q_c);

   pll_cal_sar_next #(
      .SETTLE_CYC  (SETTLE_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) u_sar_next (
      .state       (state_v),
      .bit_idx     (bit_v),
      .code        (code_v),
      .cnt         (cnt_q),
      .cal_en      (cal.cal_en),
      .start       (cal.start),
      .manual_code (cal.manual_code),
      .cmp_valid   (cal.cmp_valid),
      .vco_fast    (cal.vco_fast),
      .state_d     (state_d),
      .bit_d       (bit_d),
      .code_d      (code_d),
      .cnt_d       (cnt_d),
      .run_start   (run_start),
      .run_ok      (run_ok),
      .run_tmo     (run_tmo)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q_a <= IDLE;
         state_q_b <= IDLE;
         state_q_c <= IDLE;
         bit_q_a   <= CAL_TOP_BIT;
         bit_q_b   <= CAL_TOP_BIT;
         bit_q_c   <= CAL_TOP_BIT;
         code_q_a  <= CAL_MID_CODE;
         code_q_b  <= CAL_MID_CODE;
         code_q_c  <= CAL_MID_CODE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q_a <= state_d;
         state_q_b <= state_d;
         state_q_c <= state_d;
         bit_q_a   <= bit_d;
         bit_q_b   <= bit_d;
         bit_q_c   <= bit_d;
         code_q_a  <= code_d;
         code_q_b  <= code_d;
         code_q_c  <= code_d;
         cnt_q     <= cnt_d;
         busy_q    <= (state_d == SETTLE) || (state_d == WAIT_CMP);
         if (run_start) begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
         end
         if (run_ok) done_q <= 1'b1;
         if (run_tmo) begin
            done_q <= 1'b0;
            tmo_q  <= 1'b1;
         end
      end
   end

   assign cal.codeA       = code_q_a;
   assign cal.codeB       = code_q_b;
   assign cal.codeC       = code_q_c;
   assign cal.busy        = busy_q;
   assign cal.done        = done_q;
   assign cal.timeout_err = tmo_q;

endmodule

// File: tb/tb_pll_capbank_cal_tmr.sv
// Directed bench for pll_capbank_cal_tmr: table of SAR runs against threshold comparators,
// plus hand sequences for timeout, override, mid-run reset, busy-start and replica upsets.
module tb_pll_capbank_cal_tmr;
   import pll_cal_pkg::*;

   typedef struct packed {
      logic [5:0]       thr;
      logic [5:0][5:0]  trials;
      logic [5:0]       fin;
      logic             seu;
      logic             poke;
   } vec_t;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   vec_t tbl[5];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   pll_capbank_cal_tmr_if bus ();

   pll_capbank_cal_tmr #(
      .SETTLE_CYC  (64),
      .TIMEOUT_CYC (4096),
      .CNT_W       (13)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .cal  (bus)
   );

   function automatic vec_t mk(input int thr, input int t0, input int t1, input int t2,
                               input int t3, input int t4, input int t5, input int fin,
                               input bit seu, input bit poke);
      vec_t v;
      v.thr       = 6'(thr);
      v.trials[0] = 6'(t0);
      v.trials[1] = 6'(t1);
      v.trials[2] = 6'(t2);
      v.trials[3] = 6'(t3);
      v.trials[4] = 6'(t4);
      v.trials[5] = 6'(t5);
      v.fin       = 6'(fin);
      v.seu       = seu;
      v.poke      = poke;
      return v;
   endfunction

   function automatic logic [5:0] vote(input logic [5:0] a, input logic [5:0] b,
                                       input logic [5:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic chk_codes(input string name, input int exp);
      chk({name, " codeA"}, int'(bus.codeA), exp);
      chk({name, " codeB"}, int'(bus.codeB), exp);
      chk({name, " codeC"}, int'(bus.codeC), exp);
   endtask

   // One full calibration; the comparator answers 3 clocks after each WAIT_CMP entry.
   task automatic run_cal(input vec_t v, input int idx);
      int         c0;
      logic [5:0] vc;
      string      tag;
      tag = $sformatf("run%0d", idx);
      @(negedge clk);
      bus.start = 1'b1;
      c0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      chk({tag, " busy after start"}, int'(bus.busy), 1);
      chk({tag, " done cleared"}, int'(bus.done), 0);
      for (int t = 0; t < 6; t++) begin
         for (int k = 0; k < 64; k++) begin
            @(posedge clk);
            #1;
            if (v.poke && t == 1 && k == 20) bus.start = 1'b1;
            if (v.poke && t == 1 && k == 21) bus.start = 1'b0;
            if (v.seu && t == 2 && k == 10) begin
               force dut.code_q_b = 6'd5;
               force dut.state_q_b = DONE;
               #1;
               chk({tag, " seu injected"}, int'(bus.codeB), 5);
               #1;
               release dut.code_q_b;
               release dut.state_q_b;
            end
            if (v.seu && t == 2 && k == 11) begin
               chk_codes({tag, " seu healed"}, int'(v.trials[2]));
               chk({tag, " seu state_b"}, int'(dut.state_q_b), int'(SETTLE));
            end
         end
         @(posedge clk);
         @(posedge clk);
         @(negedge clk);
         vc = vote(bus.codeA, bus.codeB, bus.codeC);
         chk($sformatf("%s trial%0d", tag, t), int'(vc), int'(v.trials[t]));
         bus.vco_fast  = (vc <= v.thr);
         bus.cmp_valid = 1'b1;
         @(negedge clk);
         bus.cmp_valid = 1'b0;
         bus.vco_fast  = 1'b0;
      end
      chk({tag, " latency"}, cyc - c0, 6 * (64 + 3) + 1);
      chk_codes({tag, " final"}, int'(v.fin));
      chk({tag, " done"}, int'(bus.done), 1);
      chk({tag, " busy end"}, int'(bus.busy), 0);
      chk({tag, " timeout_err"}, int'(bus.timeout_err), 0);
   endtask

   initial begin
      tbl[0] = mk(37, 32, 48, 40, 36, 38, 37, 37, 1'b0, 1'b0);
      tbl[1] = mk(0, 32, 16, 8, 4, 2, 1, 0, 1'b0, 1'b0);
      tbl[2] = mk(63, 32, 48, 56, 60, 62, 63, 63, 1'b0, 1'b1);
      tbl[3] = mk(20, 32, 16, 24, 20, 22, 21, 20, 1'b0, 1'b0);
      tbl[4] = mk(37, 32, 48, 40, 36, 38, 37, 37, 1'b1, 1'b0);

      bus.cal_en      = 1'b1;
      bus.start       = 1'b0;
      bus.manual_code = 6'd0;
      bus.cmp_valid   = 1'b0;
      bus.vco_fast    = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;
      #1;
      chk_codes("reset", 32);
      chk("reset busy", int'(bus.busy), 0);
      chk("reset done", int'(bus.done), 0);
      chk("reset timeout_err", int'(bus.timeout_err), 0);

      for (int i = 0; i < 5; i++) run_cal(tbl[i], i);

      // Timeout: no verdict ever arrives.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4159) @(posedge clk);
      @(negedge clk);
      chk("tmo busy before", int'(bus.busy), 1);
      chk("tmo flag before", int'(bus.timeout_err), 0);
      @(negedge clk);
      chk_codes("tmo", 32);
      chk("tmo flag", int'(bus.timeout_err), 1);
      chk("tmo done", int'(bus.done), 0);
      chk("tmo busy", int'(bus.busy), 0);

      // Manual override from DONE: flags held, codes follow manual_code.
      bus.cal_en      = 1'b0;
      bus.manual_code = 6'd17;
      @(negedge clk);
      chk_codes("manual", 17);
      chk("manual busy", int'(bus.busy), 0);
      chk("manual tmo held", int'(bus.timeout_err), 1);
      bus.cal_en = 1'b1;
      repeat (5) @(negedge clk);
      chk("re-enable no run", int'(bus.busy), 0);
      chk_codes("re-enable hold", 17);

      // Override during SETTLE.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      chk_codes("settle code", 32);
      bus.cal_en = 1'b0;
      @(negedge clk);
      chk_codes("override mid", 17);
      chk("override busy", int'(bus.busy), 0);
      chk("override state", int'(dut.state_q_a), int'(IDLE));
      chk("override tmo cleared", int'(bus.timeout_err), 0);
      bus.cal_en = 1'b1;

      // Reset asserted in WAIT_CMP after one kept bit (code 48).
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (66) @(posedge clk);
      @(negedge clk);
      bus.cmp_valid = 1'b1;
      bus.vco_fast  = 1'b1;
      @(negedge clk);
      bus.cmp_valid = 1'b0;
      bus.vco_fast  = 1'b0;
      repeat (66) @(posedge clk);
      @(negedge clk);
      chk_codes("pre-reset", 48);
      rstn = 1'b0;
      #1;
      chk_codes("async reset", 32);
      chk("async reset busy", int'(bus.busy), 0);
      chk("async reset state", int'(dut.state_q_a), int'(IDLE));
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      chk_codes("after reset", 32);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
